// File: rtl/ws_column_sequencer.sv
// ws_column_sequencer: loads ROWS weights into a weight-stationary PE column,
// streams skewed activation vectors through it and returns the column sums.
module ws_column_sequencer #(
   parameter int WORD_WIDTH = 8,
   parameter int ROWS       = 4,
   parameter int PSUM_WIDTH = WORD_WIDTH*4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [15:0]                num_vecs,
   output logic                       busy,
   output logic                       done,
   input  logic                       w_valid,
   output logic                       w_ready,
   input  logic [WORD_WIDTH-1:0]      w_data,
   input  logic                       act_valid,
   output logic                       act_ready,
   input  logic [WORD_WIDTH*ROWS-1:0] act_data,
   output logic [1:0]                 pe_control,
   output logic [WORD_WIDTH*ROWS-1:0] pe_a,
   output logic [PSUM_WIDTH-1:0]      pe_d,
   input  logic [PSUM_WIDTH-1:0]      pe_d_ret,
   output logic                       res_valid,
   output logic [PSUM_WIDTH-1:0]      res_data
);

   localparam int CW = $clog2(ROWS+1);
   localparam logic [CW-1:0] W_LAST = CW'(ROWS-1);

   typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [15:0]           num_q, num_d;
   logic [15:0]           vcnt_q, vcnt_d;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic [ROWS:0]         tag_q, tag_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  w_ready_q, w_ready_d;
   logic                  act_ready_q, act_ready_d;
   logic [1:0]            ctrl_q, ctrl_d;
   logic [PSUM_WIDTH-1:0] pe_d_q, pe_d_d;
   logic                  res_valid_q, res_valid_d;
   logic [PSUM_WIDTH-1:0] res_data_q, res_data_d;
   logic                  w_acc, a_acc;

   assign w_acc = w_valid & w_ready_q;
   assign a_acc = act_valid & act_ready_q;

   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      vcnt_d      = vcnt_q;
      wcnt_d      = wcnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      w_ready_d   = 1'b0;
      act_ready_d = 1'b0;
      ctrl_d      = 2'b00;
      pe_d_d      = pe_d_q;
      // tag marks a real vector travelling alongside the psum wavefront
      tag_d       = {tag_q[ROWS-1:0], a_acc};
      res_valid_d = tag_q[ROWS];
      res_data_d  = tag_q[ROWS] ? pe_d_ret : res_data_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               num_d     = num_vecs;
               vcnt_d    = '0;
               wcnt_d    = '0;
               busy_d    = 1'b1;
               w_ready_d = 1'b1;
            end
         end
         LOAD: begin
            w_ready_d = 1'b1;
            if (w_acc) begin
               ctrl_d = 2'b01;
               pe_d_d = {{(PSUM_WIDTH-WORD_WIDTH){1'b0}}, w_data};
               wcnt_d = wcnt_q + 1'b1;
               if (wcnt_q == W_LAST) begin
                  w_ready_d = 1'b0;
                  if (num_q == '0) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                  end else begin
                     state_d     = FEED;
                     act_ready_d = 1'b1;
                  end
               end
            end
         end
         FEED: begin
            ctrl_d      = 2'b10;
            pe_d_d      = '0;
            act_ready_d = 1'b1;
            if (a_acc) begin
               vcnt_d = vcnt_q + 16'd1;
               if (vcnt_d == num_q) begin
                  act_ready_d = 1'b0;
                  state_d     = DRAIN;
               end
            end
         end
         DRAIN: begin
            ctrl_d = 2'b10;
            pe_d_d = '0;
            if (tag_q == '0) begin
               ctrl_d  = 2'b00;
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         num_q       <= '0;
         vcnt_q      <= '0;
         wcnt_q      <= '0;
         tag_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         w_ready_q   <= 1'b0;
         act_ready_q <= 1'b0;
         ctrl_q      <= 2'b00;
         pe_d_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         vcnt_q      <= vcnt_d;
         wcnt_q      <= wcnt_d;
         tag_q       <= tag_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         w_ready_q   <= w_ready_d;
         act_ready_q <= act_ready_d;
         ctrl_q      <= ctrl_d;
         pe_d_q      <= pe_d_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   // lane r is delayed r extra cycles so each row sees its input on time
   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [WORD_WIDTH*(r+1)-1:0] dl_q;
      logic [WORD_WIDTH-1:0]       in_w;
      assign in_w = a_acc ? act_data[r*WORD_WIDTH +: WORD_WIDTH] : '0;
      if (r == 0) begin : g_first
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) dl_q <= '0;
            else          dl_q <= in_w;
         end
      end else begin : g_rest
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) dl_q <= '0;
            else          dl_q <= {dl_q[WORD_WIDTH*r-1:0], in_w};
         end
      end
      assign pe_a[r*WORD_WIDTH +: WORD_WIDTH] =
         dl_q[WORD_WIDTH*(r+1)-1 -: WORD_WIDTH];
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign w_ready    = w_ready_q;
   assign act_ready  = act_ready_q;
   assign pe_control = ctrl_q;
   assign pe_d       = pe_d_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;

endmodule

// File: tb/tb_ws_column_sequencer.sv
// tb_ws_column_sequencer: drives the sequencer against a behavioural PE
// column and scoreboards the returned column dot products.
module tb_ws_column_sequencer;

   localparam int W = 8;
   localparam int R = 4;
   localparam int P = 32;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           start;
   logic [15:0]    num_vecs;
   logic           busy, done;
   logic           w_valid, w_ready;
   logic [W-1:0]   w_data;
   logic           act_valid, act_ready;
   logic [W*R-1:0] act_data;
   logic [1:0]     pe_control;
   logic [W*R-1:0] pe_a;
   logic [P-1:0]   pe_d, pe_d_ret;
   logic           res_valid;
   logic [P-1:0]   res_data;

   ws_column_sequencer #(.WORD_WIDTH(W), .ROWS(R), .PSUM_WIDTH(P)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .num_vecs(num_vecs),
      .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready),
      .w_data(w_data), .act_valid(act_valid), .act_ready(act_ready),
      .act_data(act_data), .pe_control(pe_control), .pe_a(pe_a),
      .pe_d(pe_d), .pe_d_ret(pe_d_ret), .res_valid(res_valid),
      .res_data(res_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // behavioural PE column: weights shift down on 01, psums flow on 10
   logic [P-1:0] wreg[R];
   logic [P-1:0] dreg[R];
   initial for (int r = 0; r < R; r++) begin wreg[r] = '0; dreg[r] = '0; end
   always @(posedge clk) begin
      if (pe_control == 2'b01) begin
         wreg[0] <= pe_d;
         for (int r = 1; r < R; r++) wreg[r] <= wreg[r-1];
      end else if (pe_control == 2'b10) begin
         dreg[0] <= pe_d + pe_a[W-1:0] * wreg[0];
         for (int r = 1; r < R; r++)
            dreg[r] <= dreg[r-1] + pe_a[r*W +: W] * wreg[r];
      end
   end
   assign pe_d_ret = dreg[R-1];

   typedef struct { logic v; logic [W*R-1:0] a; logic [P-1:0] exp; } vec_t;
   typedef struct { logic [P-1:0] d; int due; } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   exp_t e_pop;
   int   checks = 0;
   int   errors = 0;
   int   res_cnt = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1 && res_valid === 1'b1) begin
         res_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_res actual=%0h required=none", res_data);
         end else begin
            e_pop = sb.pop_front();
            chk("res_data", res_data, e_pop.d);
            chk("res_latency", cyc, e_pop.due);
         end
      end
   end

   function automatic logic [W*R-1:0] vec(input int a0, a1, a2, a3);
      return {W'(a3), W'(a2), W'(a1), W'(a0)};
   endfunction

   task automatic add(input logic v, input logic [W*R-1:0] a,
                      input logic [P-1:0] ex);
      vec_t t;
      t.v = v; t.a = a; t.exp = ex;
      tbl.push_back(t);
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      num_vecs = 16'(n);
      @(negedge clk);
      start = 1'b0;
      num_vecs = 16'd9;
      chk("busy_up", busy, 1);
      chk("w_ready_up", w_ready, 1);
   endtask

   task automatic load(input bit stall);
      int c0;
      c0 = cyc;
      for (int k = 1; k <= R; k++) begin
         chk("w_ready", w_ready, 1);
         w_valid = 1'b1;
         w_data = W'(k);
         @(negedge clk);
         chk("ld_ctrl", pe_control, 2'b01);
         chk("ld_d", pe_d, k);
         if (stall && k == 2) begin
            w_valid = 1'b0;
            w_data = 8'hAA;
            @(negedge clk);
            chk("stall_ctrl", pe_control, 2'b00);
            chk("stall_d", pe_d, 2);
         end
      end
      w_valid = 1'b0;
      w_data = '0;
      chk("w_ready_drop", w_ready, 0);
      chk("load_cycles", cyc - c0, stall ? 5 : 4);
   endtask

   task automatic feed();
      exp_t e;
      foreach (tbl[i]) begin
         act_valid = tbl[i].v;
         act_data = tbl[i].a;
         if (tbl[i].v) begin
            chk("act_ready", act_ready, 1);
            e.d = tbl[i].exp;
            e.due = cyc + R + 2;
            sb.push_back(e);
         end
         @(negedge clk);
      end
      act_valid = 1'b0;
      act_data = '0;
      chk("act_ready_end", act_ready, 0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
      chk("done_seen", done, 1);
      chk("busy_at_done", busy, 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic single_vec();
      exp_t e;
      act_valid = 1'b1;
      act_data = vec(1, 1, 1, 1);
      chk("act_ready", act_ready, 1);
      e.d = 10;
      e.due = cyc + R + 2;
      sb.push_back(e);
      @(negedge clk);
      act_valid = 1'b0;
      act_data = '0;
      for (int r = 0; r < R; r++) begin
         if (r == 0) chk("feed_ctrl", pe_control, 2'b10);
         chk("skew_lane", pe_a, 32'h1 << (W*r));
         @(negedge clk);
      end
      wait_done();
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      num_vecs = '0;
      w_valid = 1'b0;
      w_data = '0;
      act_valid = 1'b0;
      act_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_outs", {busy, done, w_ready, act_ready, pe_control, pe_a,
                       pe_d, res_valid, res_data}, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_ctrl", pe_control, 2'b00);

      // load 1..4 then one all-ones vector
      res_cnt = 0;
      do_start(1);
      load(0);
      single_vec();
      chk("single_cnt", res_cnt, 1);

      // three vectors separated by bubbles
      res_cnt = 0;
      do_start(3);
      load(0);
      tbl.delete();
      add(1, vec(1, 0, 0, 0), 4);
      add(0, '0, 0);
      add(0, '0, 0);
      add(1, vec(0, 2, 0, 0), 6);
      add(0, '0, 0);
      add(0, '0, 0);
      add(1, vec(0, 0, 0, 5), 5);
      feed();
      wait_done();
      chk("bubble_cnt", res_cnt, 3);

      // weight stall on the third weight slot
      res_cnt = 0;
      do_start(1);
      load(1);
      tbl.delete();
      add(1, vec(2, 0, 0, 1), 9);
      feed();
      wait_done();
      chk("stall_cnt", res_cnt, 1);

      // empty job
      res_cnt = 0;
      do_start(0);
      load(0);
      chk("zero_act_ready", act_ready, 0);
      wait_done();
      repeat (6) @(negedge clk);
      chk("zero_cnt", res_cnt, 0);

      // start raised during FEED must not restart or relatch num_vecs
      res_cnt = 0;
      do_start(2);
      load(0);
      start = 1'b1;
      num_vecs = 16'd7;
      tbl.delete();
      add(1, vec(1, 1, 1, 1), 10);
      add(1, vec(2, 0, 0, 1), 9);
      feed();
      start = 1'b0;
      chk("feed_busy", busy, 1);
      wait_done();
      chk("ign_start_cnt", res_cnt, 2);

      // asynchronous reset in the middle of FEED
      res_cnt = 0;
      do_start(3);
      load(0);
      act_valid = 1'b1;
      act_data = vec(3, 3, 3, 3);
      @(negedge clk);
      act_data = vec(1, 2, 3, 4);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_outs", {busy, done, w_ready, act_ready, pe_control, pe_a,
                          pe_d, res_valid, res_data}, 0);
      act_valid = 1'b0;
      act_data = '0;
      sb.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("midrst_no_res", res_cnt, 0);
      do_start(1);
      load(0);
      single_vec();
      chk("post_rst_cnt", res_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
